sub_seq_16b: RTL and testbench
==============================

# sub_seq_16b

Multi-cycle 16-bit subtractor and the companion to the 4-bit carry-lookahead adder slice. It computes a − b − borrow_in four bits per cycle using a 4-bit borrow-lookahead slice. Operands come in and results go out over valid/ready handshakes. It sits in the ALU path for SUB/compare operations where a short multi-cycle latency is acceptable.

## Interface
Parameters:
- WIDTH, 16, operand width; must be a multiple of 4
- SLICE, 4, bits per cycle; fixed

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- b_in  in  1  borrow-in
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- diff  out  WIDTH  (a − b − b_in) mod 2^WIDTH
- b_out  out  1  unsigned borrow: 1 iff a < b + b_in
- ovf  out  1  signed overflow: true result is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1]
- zero  out  1  1 iff diff == 0

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - in_ready = 1.
  - An accept happens on in_valid && in_ready. It latches a, b and b_in, clears the slice counter, then goes to BUSY.
- **BUSY**
  - Each cycle, slice k (bits 4k+3:4k) is processed using the registered borrow.
  - Borrow-lookahead terms per bit i: G_i = ~a_i & b_i; P_i = ~(a_i ^ b_i).
  - Borrow recurrence: B_{i+1} = G_i | P_i & B_i.
  - Difference bit: d_i = a_i ^ b_i ^ B_i.
  - The slice result is written into the diff register and the borrow register is updated.
  - After slice WIDTH/4−1, go to DONE.
- **DONE**
  - out_valid = 1.
  - diff, b_out, ovf and zero are stable and held.
  - On out_valid && out_ready, go to IDLE.
- Flag definitions:
  - ovf = borrow into MSB XOR borrow out of MSB.
  - b_out = final borrow.
- in_ready = 0 in BUSY and DONE. Input changes during those states are ignored because operands are latched.
- No new accept in the DONE→IDLE handshake cycle.
- **Reset**
  - Asynchronous and immediate from any state, including mid-BUSY.
  - State goes to IDLE; diff = 0; b_out = ovf = zero = out_valid = 0.
  - in_ready is 0 while rst_n is low and 1 in the first cycle after release.
  - An operation in flight is discarded; no partial result is ever presented.

## Timing
- Latency: accept at edge N, then out_valid is high after edge N+WIDTH/4 (N+4 at default).
- Minimum op spacing is WIDTH/4+2 cycles, with out_ready held high.
- Outputs are registered. in_ready and out_valid are decoded from the state register only, with no combinational path from inputs.
- Backpressure: while out_ready is low in DONE, all outputs are held with no limit on duration.

## Structure
- Shared package sub_pkg holds:
  - state encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10)
  - SLICE = 4
- Sub-module bla_4b is a combinational 4-bit borrow-lookahead slice.
  - Ports: a[3:0], b[3:0], b_in, diff[3:0], b_out, b_msb_in (borrow into bit 3, used for ovf).
  - It uses two-level lookahead for B1..B4, the same form as the carry lookahead with G/P redefined for borrow.
- Top level holds:
  - FSM
  - slice counter (log2(WIDTH/4) bits)
  - operand, diff and borrow registers
  - slice mux/demux

## Test plan
- Basic subtract: a=0x1234, b=0x0234, b_in=0.
  - Result: diff=0x1000, b_out=0, ovf=0, zero=0.
  - out_valid rises exactly 4 cycles after accept.
- Unsigned borrow: a=0x0000, b=0x0001.
  - Result: diff=0xFFFF, b_out=1, ovf=0.
- Signed overflow: a=0x8000, b=0x0001 gives diff=0x7FFF, ovf=1, b_out=0.
  - Also a=0x7FFF, b=0xFFFF gives diff=0x8000, ovf=1, b_out=1.
- Borrow-in and zero flag: a=0x0005, b=0x0004, b_in=1.
  - Result: diff=0x0000, zero=1, b_out=0.
- Backpressure and operand isolation:
  - Change a/b every cycle during BUSY; the result must match the latched operands.
  - Hold out_ready low 3 cycles in DONE; outputs must be stable and in_ready=0.
  - Release out_ready; IDLE must follow next cycle.
- Reset mid-operation:
  - Assert rst_n=0 two cycles into BUSY.
  - While reset is low: out_valid=0 and diff=0 immediately, and in_ready=0.
  - After release: in_ready=1, and the next op 0x00FF−0x000F yields 0x00F0.

Source files
------------

// File: rtl/sub_pkg.sv
// sub_pkg: shared state encodings and slice width for the sequential subtractor
package sub_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;
  localparam int SLICE = 4;
endpackage

// File: rtl/bla_4b.sv
// bla_4b: combinational 4-bit borrow-lookahead subtract slice
module bla_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       b_in,
  output logic [3:0] diff,
  output logic       b_out,
  output logic       b_msb_in
);
  logic [3:0] g, p;
  logic [4:0] br;
  assign g = ~a & b;
  assign p = ~(a ^ b);
  // two-level lookahead: every borrow is a flat sum of generate/propagate products
  always_comb begin
    br[0] = b_in;
    br[1] = g[0] | p[0] & b_in;
    br[2] = g[1] | p[1] & g[0] | p[1] & p[0] & b_in;
    br[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & b_in;
    br[4] = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0]
          | p[3] & p[2] & p[1] & p[0] & b_in;
  end
  assign diff     = a ^ b ^ br[3:0];
  assign b_out    = br[4];
  assign b_msb_in = br[3];
endmodule

// File: rtl/sub_seq_16b.sv
// sub_seq_16b: multi-cycle subtractor, one 4-bit borrow-lookahead slice per cycle
module sub_seq_16b #(
  parameter int WIDTH = 16,
  parameter int SLICE = sub_pkg::SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);
  import sub_pkg::*;
  localparam int NS = WIDTH / SLICE;
  localparam int CW = NS > 1 ? $clog2(NS) : 1;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, diff_nxt;
  logic             brw, last, s_bout, s_bmsb;
  logic [SLICE-1:0] s_diff;
  bla_4b u_bla (
    .a        (a_r[cnt*SLICE +: SLICE]),
    .b        (b_r[cnt*SLICE +: SLICE]),
    .b_in     (brw),
    .diff     (s_diff),
    .b_out    (s_bout),
    .b_msb_in (s_bmsb)
  );
  assign last = cnt == CW'(NS - 1);
  // splice the current slice result into the accumulated difference
  always_comb begin
    diff_nxt = diff;
    diff_nxt[cnt*SLICE +: SLICE] = s_diff;
  end
  // FSM with registered handshake outputs; in_ready stays low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      brw       <= 1'b0;
      diff      <= '0;
      b_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b;
            brw      <= b_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          diff <= diff_nxt;
          brw  <= s_bout;
          cnt  <= cnt + 1'b1;
          if (last) begin
            b_out     <= s_bout;
            ovf       <= s_bmsb ^ s_bout;
            zero      <= diff_nxt == '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sub_seq_16b.sv
// tb_sub_seq_16b: scoreboard bench with directed subtract vectors, backpressure and mid-op reset
module tb_sub_seq_16b;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, b_in, out_valid, out_ready, b_out, ovf, zero;
  logic [15:0] a, b, diff;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic [15:0] d;
    logic        bo, ov, z;
  } exp_t;

  typedef struct {
    logic [15:0] va, vb;
    logic        vbin;
    logic [15:0] d;
    logic        bo, ov, z;
    int          bp;
  } vec_t;

  exp_t sb[$];
  exp_t got;

  vec_t vecs[9] = '{
    '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 0},
    '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0},
    '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 0},
    '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 0},
    '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 0},
    '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0},
    '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0, 0},
    '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0},
    '{16'h4321, 16'h1111, 1'b0, 16'h3210, 1'b0, 1'b0, 1'b0, 3}
  };

  sub_seq_16b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops the oldest expected result whenever a result is handed over
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
      else begin
        got = sb.pop_front();
        chk("diff", 32'(diff), 32'(got.d));
        chk("b_out", 32'(b_out), 32'(got.bo));
        chk("ovf", 32'(ovf), 32'(got.ov));
        chk("zero", 32'(zero), 32'(got.z));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input vec_t v);
    int t = 0;
    int lat = 0;
    logic [15:0] d0;
    logic [2:0] f0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    chk("in_ready_wait", 32'(t < 20), 32'd1);
    a = v.va; b = v.vb; b_in = v.vbin; in_valid = 1'b1;
    out_ready = (v.bp == 0);
    sb.push_back('{v.d, v.bo, v.ov, v.z});
    @(posedge clk); #1;
    while (!out_valid && lat < 10) begin
      a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'd4);
    if (v.bp > 0) begin
      d0 = diff; f0 = {b_out, ovf, zero};
      for (int i = 0; i < v.bp; i++) begin
        a = 16'($urandom); b = 16'($urandom);
        @(posedge clk); #1;
        chk("bp_diff_stable", 32'(diff), 32'(d0));
        chk("bp_flags_stable", 32'({b_out, ovf, zero}), 32'(f0));
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; b_in = 1'b0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_flags", 32'({b_out, ovf, zero}), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    foreach (vecs[i]) send(vecs[i]);
    // abort an operation two cycles into BUSY
    a = 16'hFFFF; b = 16'h0000; b_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_hold_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_hold_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rel_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_rel_out_valid", 32'(out_valid), 32'd0);
    send('{16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 0});
    t = 0;
    while (sb.size() != 0 && t < 20) begin @(posedge clk); #1; t++; end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
